count_cmd_controller: RTL and testbench

COUNT_CMD_CONTROLLER -- requirements
Module: count_cmd_controller

---
 rtl/count_cmd_controller.sv | 147 ++++++++++++++
 tb/tb_count_cmd_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/count_cmd_controller.sv
// Up/down button command controller: turns held button levels into one-cycle
// increment/decrement/clear commands for a BCD counter, with hold-then-repeat timing.
module count_cmd_controller #(
  parameter logic [15:0] HOLD_CYCLES   = 16'd50000,
  parameter logic [15:0] REPEAT_CYCLES = 16'd12500
) (
  input  logic       sysclock,
  input  logic       reset,
  input  logic       up_lvl,
  input  logic       down_lvl,
  input  logic       sat_en,
  input  logic       at_max,
  input  logic       at_min,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       clr_pulse,
  output logic [2:0] state,
  output logic       repeating
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StUpHold = 3'd1,
    StUpRpt  = 3'd2,
    StDnHold = 3'd3,
    StDnRpt  = 3'd4,
    StBoth   = 3'd5
  } state_e;

  localparam logic [15:0] HoldLast   = HOLD_CYCLES - 16'd1;
  localparam logic [15:0] RepeatLast = REPEAT_CYCLES - 16'd1;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        inc_q, inc_d;
  logic        dec_q, dec_d;
  logic        clr_q, clr_d;
  logic        repeating_q, repeating_d;
  logic        inc_req, dec_req;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    inc_req = 1'b0;
    dec_req = 1'b0;
    clr_d   = 1'b0;

    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (up_lvl && down_lvl) begin
          state_d = StBoth;
          clr_d   = 1'b1;
        end else if (up_lvl) begin
          state_d = StUpHold;
          inc_req = 1'b1;
        end else if (down_lvl) begin
          state_d = StDnHold;
          dec_req = 1'b1;
        end
      end

      // Opposite button wins over release and over any repeat due on the same edge.
      StUpHold, StUpRpt: begin
        if (down_lvl) begin
          state_d = StBoth;
          timer_d = '0;
          clr_d   = 1'b1;
        end else if (!up_lvl) begin
          state_d = StIdle;
          timer_d = '0;
        end else if ((state_q == StUpHold) && (timer_q == HoldLast)) begin
          state_d = StUpRpt;
          timer_d = '0;
          inc_req = 1'b1;
        end else if ((state_q == StUpRpt) && (timer_q == RepeatLast)) begin
          timer_d = '0;
          inc_req = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      StDnHold, StDnRpt: begin
        if (up_lvl) begin
          state_d = StBoth;
          timer_d = '0;
          clr_d   = 1'b1;
        end else if (!down_lvl) begin
          state_d = StIdle;
          timer_d = '0;
        end else if ((state_q == StDnHold) && (timer_q == HoldLast)) begin
          state_d = StDnRpt;
          timer_d = '0;
          dec_req = 1'b1;
        end else if ((state_q == StDnRpt) && (timer_q == RepeatLast)) begin
          timer_d = '0;
          dec_req = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      StBoth: begin
        timer_d = '0;
        if (!up_lvl && !down_lvl) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase

    // Saturation only masks the command; state and timer advance regardless.
    inc_d       = inc_req & ~(sat_en & at_max);
    dec_d       = dec_req & ~(sat_en & at_min);
    repeating_d = (state_d == StUpRpt) || (state_d == StDnRpt);
  end

  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      clr_q       <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      clr_q       <= clr_d;
      repeating_q <= repeating_d;
    end
  end

  assign state     = state_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign clr_pulse = clr_q;
  assign repeating = repeating_q;

endmodule

// File: tb/tb_count_cmd_controller.sv
// Directed bench for count_cmd_controller with HOLD_CYCLES=8, REPEAT_CYCLES=4.
module tb_count_cmd_controller;

  logic       sysclock = 1'b0;
  logic       reset    = 1'b0;
  logic       up_lvl   = 1'b0;
  logic       down_lvl = 1'b0;
  logic       sat_en   = 1'b0;
  logic       at_max   = 1'b0;
  logic       at_min   = 1'b0;
  logic       inc_pulse, dec_pulse, clr_pulse, repeating;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  count_cmd_controller #(
    .HOLD_CYCLES  (16'd8),
    .REPEAT_CYCLES(16'd4)
  ) dut (
    .sysclock (sysclock),
    .reset    (reset),
    .up_lvl   (up_lvl),
    .down_lvl (down_lvl),
    .sat_en   (sat_en),
    .at_max   (at_max),
    .at_min   (at_min),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .clr_pulse(clr_pulse),
    .state    (state),
    .repeating(repeating)
  );

  always #5 sysclock = ~sysclock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge sysclock);
    #1;
  endtask

  // Pulses packed as {inc, dec, clr}: 4 = inc, 2 = dec, 1 = clr.
  task automatic check_outs(input string tag, input int e, input logic [2:0] exp_p,
                            input logic [2:0] exp_s, input logic exp_r);
    check($sformatf("%s e%0d pulses", tag, e), {13'd0, inc_pulse, dec_pulse, clr_pulse},
          {13'd0, exp_p});
    check($sformatf("%s e%0d state", tag, e), {13'd0, state}, {13'd0, exp_s});
    check($sformatf("%s e%0d repeating", tag, e), {15'd0, repeating}, {15'd0, exp_r});
  endtask

  task automatic idle_gap();
    up_lvl   = 1'b0;
    down_lvl = 1'b0;
    sat_en   = 1'b0;
    at_max   = 1'b0;
    at_min   = 1'b0;
    tick();
    tick();
  endtask

  // Up held for edges 0-19; sat masks every inc but not the state sequence.
  task automatic run_up(input string tag, input logic sat);
    logic [2:0] ep, es;
    sat_en = sat;
    at_max = sat;
    for (int e = 0; e <= 22; e++) begin
      up_lvl = (e <= 19);
      tick();
      ep = (!sat && (e == 0 || e == 8 || e == 12 || e == 16)) ? 3'b100 : 3'b000;
      es = (e < 8) ? 3'd1 : (e < 20) ? 3'd2 : 3'd0;
      check_outs(tag, e, ep, es, (e >= 8) && (e < 20));
    end
    idle_gap();
  endtask

  // Down held for 3 edges.
  task automatic run_down(input string tag, input logic sat, input logic amin,
                          input logic amax, input logic expect_dec);
    sat_en = sat;
    at_min = amin;
    at_max = amax;
    for (int e = 0; e <= 4; e++) begin
      down_lvl = (e < 3);
      tick();
      check_outs(tag, e, (e == 0 && expect_dec) ? 3'b010 : 3'b000,
                 (e < 3) ? 3'd3 : 3'd0, 1'b0);
    end
    idle_gap();
  endtask

  initial begin
    // Async reset with no clock edge yet (first posedge at 5 ns).
    #1 reset = 1'b1;
    #1;
    check("reset async state", {13'd0, state}, 16'd0);
    check("reset async pulses", {13'd0, inc_pulse, dec_pulse, clr_pulse}, 16'd0);
    check("reset async repeating", {15'd0, repeating}, 16'd0);
    @(posedge sysclock);
    @(negedge sysclock);
    reset = 1'b0;
    tick();
    check_outs("idle", 0, 3'b000, 3'd0, 1'b0);

    run_up("up", 1'b0);
    run_up("upsat", 1'b1);

    run_down("dn", 1'b0, 1'b0, 1'b0, 1'b1);
    run_down("dnsat", 1'b1, 1'b1, 1'b0, 1'b0);
    run_down("dnmax", 1'b1, 1'b0, 1'b1, 1'b1);

    // Down joins at edge 10 (mid-repeat), released at 15; up released at 17.
    for (int e = 0; e <= 19; e++) begin
      logic [2:0] ep, es;
      up_lvl   = (e <= 16);
      down_lvl = (e >= 10) && (e <= 14);
      tick();
      ep = (e == 0 || e == 8) ? 3'b100 : (e == 10) ? 3'b001 : 3'b000;
      es = (e < 8) ? 3'd1 : (e < 10) ? 3'd2 : (e < 17) ? 3'd5 : 3'd0;
      check_outs("both", e, ep, es, (e == 8) || (e == 9));
    end
    idle_gap();

    // Both pressed on the same edge from idle.
    for (int e = 0; e <= 2; e++) begin
      up_lvl   = (e < 2);
      down_lvl = (e < 2);
      tick();
      check_outs("same", e, (e == 0) ? 3'b001 : 3'b000, (e < 2) ? 3'd5 : 3'd0, 1'b0);
    end
    idle_gap();

    // 1 ns reset while inc_pulse is high in UP_RPT, button still held.
    for (int e = 0; e <= 12; e++) begin
      up_lvl = 1'b1;
      tick();
      check_outs("prerst", e,
                 (e == 0 || e == 8 || e == 12) ? 3'b100 : 3'b000,
                 (e < 8) ? 3'd1 : 3'd2, e >= 8);
    end
    reset = 1'b1;
    #1;
    check_outs("midrst", 0, 3'b000, 3'd0, 1'b0);
    reset = 1'b0;
    for (int r = 0; r <= 9; r++) begin
      tick();
      check_outs("postrst", r, (r == 0 || r == 8) ? 3'b100 : 3'b000,
                 (r < 8) ? 3'd1 : 3'd2, r >= 8);
    end
    idle_gap();
    check_outs("final", 0, 3'b000, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
